input_buffer_xy: RTL and testbench

Per-port input buffer and route computation stage that sits directly upstream of the five-port output arbiter. It accepts flits from a neighbouring router (or the local core) over an RTS/CTS handshake and stores them in a small FIFO. It computes the XY-routed output direction from each header flit and drives a one-hot `Req_N/E/W/S/L` toward the arbiters until the packet's tail flit has been drained. One instance exists per router input port.

---
 rtl/input_buffer_xy_if.sv | 32 +++
 rtl/input_buffer_xy.sv | 139 +++++++++++++
 tb/tb_input_buffer_xy.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_buffer_xy_if.sv
// Flit-side and arbiter-side signals of one router input port.
// master: upstream neighbour plus arbiters; slave: the input buffer.
interface input_buffer_xy_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] RX;
  logic                  DRTS;
  logic                  CTS;
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  Req_N;
  logic                  Req_E;
  logic                  Req_W;
  logic                  Req_S;
  logic                  Req_L;
  logic                  err;

  modport master (
    output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, Req_N, Req_E, Req_W, Req_S, Req_L, err
  );

  modport slave (
    input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, Req_N, Req_E, Req_W, Req_S, Req_L, err
  );
endinterface

// File: rtl/input_buffer_xy.sv
// Router input port: RTS/CTS receive FIFO with first-word-fall-through head
// and XY route request held from header until the tail flit is popped.
module input_buffer_xy #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int COORD_W    = 4,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input_buffer_xy_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [2:0]       T_HEADER = 3'b001;
  localparam logic [2:0]       T_TAIL   = 3'b100;
  localparam logic [COORD_W-1:0] CX     = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY     = COORD_W'(CUR_Y);

  // Request vector bit order: {N, E, W, S, L}
  localparam logic [4:0] R_N = 5'b10000;
  localparam logic [4:0] R_E = 5'b01000;
  localparam logic [4:0] R_W = 5'b00100;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_L = 5'b00001;

  typedef enum logic {IDLE, ROUTED} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic                  cts_q;
  logic                  err_q, err_d;
  logic [4:0]            req_q, req_d;
  state_e                state_q, state_d;

  logic                  empty_w, full_w, wr, ext_pop, discard, pop;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            head_type;
  logic [COORD_W-1:0]    dest_x, dest_y;
  logic [4:0]            route;

  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == FULL_CNT);
  assign wr        = cts_q & ~full_w;
  assign ext_pop   = (bus.read_en_N | bus.read_en_E | bus.read_en_W |
                      bus.read_en_S | bus.read_en_L) & ~empty_w;
  assign pop       = ext_pop | discard;

  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[DATA_WIDTH-1:DATA_WIDTH-3];
  assign dest_x    = head[2*COORD_W-1:COORD_W];
  assign dest_y    = head[COORD_W-1:0];

  always_comb begin
    count_d = count_q;
    if (wr && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cts_q   <= bus.DRTS & ~cts_q & ~full_w;
      count_q <= count_d;
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= bus.RX;
  end

  always_comb begin
    route = R_L;
    if (dest_x > CX)      route = R_E;
    else if (dest_x < CX) route = R_W;
    else if (dest_y > CY) route = R_S;
    else if (dest_y < CY) route = R_N;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty_w && !ext_pop && head_type == T_HEADER) state_d = ROUTED;
      ROUTED:  if (ext_pop && head_type == T_TAIL)                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A non-header reaching the head outside a packet is dropped on the spot.
  always_comb begin
    req_d   = req_q;
    err_d   = err_q;
    discard = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_w && head_type != T_HEADER) begin
          discard = 1'b1;
          err_d   = 1'b1;
        end else if (!empty_w && !ext_pop) begin
          req_d = route;
        end
      end
      ROUTED:  if (ext_pop && head_type == T_TAIL) req_d = '0;
      default: req_d = '0;
    endcase
  end

  assign bus.CTS      = cts_q;
  assign bus.Data_out = head;
  assign bus.empty    = empty_w;
  assign bus.Req_N    = req_q[4];
  assign bus.Req_E    = req_q[3];
  assign bus.Req_W    = req_q[2];
  assign bus.Req_S    = req_q[1];
  assign bus.Req_L    = req_q[0];
  assign bus.err      = err_q;

endmodule

// File: tb/tb_input_buffer_xy.sv
// Scoreboard bench for input_buffer_xy at router (1,1): a packet-level model
// predicts delivered flits and their direction; a monitor checks every pop.
module tb_input_buffer_xy;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_buffer_xy_if #(.DATA_WIDTH(32)) bus ();

  input_buffer_xy #(
    .DATA_WIDTH(32),
    .DEPTH(4),
    .COORD_W(4),
    .CUR_X(1),
    .CUR_Y(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [4:0] rd_sel = '0;
  logic [4:0] reqv;
  assign bus.read_en_N = rd_sel[4];
  assign bus.read_en_E = rd_sel[3];
  assign bus.read_en_W = rd_sel[2];
  assign bus.read_en_S = rd_sel[1];
  assign bus.read_en_L = rd_sel[0];
  assign reqv = {bus.Req_N, bus.Req_E, bus.Req_W, bus.Req_S, bus.Req_L};

  typedef struct {
    logic [31:0] f;
    logic [4:0]  dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   in_pkt = 0;
  logic [4:0] cur_dir = '0;
  logic err_exp = 1'b0;

  int arb_mode = 0;     // 0 off, 1 random, 2 counted pops, 3 counted pops only while CTS
  int arb_want = 0;
  int arb_served = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] xy_dir(input int dx, input int dy);
    if (dx > 1) return 5'b01000;
    if (dx < 1) return 5'b00100;
    if (dy > 1) return 5'b00010;
    if (dy < 1) return 5'b10000;
    return 5'b00001;
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] t, input int dx, input int dy);
    logic [20:0] pay;
    pay = 21'($urandom);
    return {t, pay, 4'(dx), 4'(dy)};
  endfunction

  // Packet-level reference: what leaves the buffer, and toward which port.
  task automatic model_push(input logic [31:0] f);
    exp_t e;
    logic [2:0] t;
    t = f[31:29];
    if (t == HDR) begin
      in_pkt  = 1;
      cur_dir = xy_dir(int'(f[7:4]), int'(f[3:0]));
    end else if (!in_pkt) begin
      err_exp = 1'b1;
      return;
    end
    e.f = f;
    e.dir = cur_dir;
    exp_q.push_back(e);
    if (t == TAIL) in_pkt = 0;
  endtask

  task automatic send_flit(input logic [31:0] f);
    bit got = 0;
    bus.RX = f;
    bus.DRTS = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.CTS) got = 1;
    end
    if (got) begin
      model_push(f);
      @(posedge clk); #1;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL cts_timeout: got CTS=0 for 200 cycles, required CTS=1");
    end
    bus.DRTS = 1'b0;
  endtask

  task automatic send_pkt(input int dx, input int dy, input int nbody);
    send_flit(mk(HDR, dx, dy));
    for (int b = 0; b < nbody; b++) send_flit(mk(BODY, dx, dy));
    send_flit(mk(TAIL, dx, dy));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !bus.empty) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_left"}, 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    check({name, "_req_idle"}, 32'(reqv), 0);
    check({name, "_empty"}, 32'(bus.empty), 1);
  endtask

  // Arbiter stand-in: grants only the direction the buffer is requesting.
  initial begin
    forever begin
      @(posedge clk); #1;
      rd_sel = '0;
      case (arb_mode)
        1: begin
          if (reqv != 0 && $urandom % 3 != 0) rd_sel = reqv;
          else if (bus.empty && $urandom % 8 == 0) rd_sel = 5'b00001 << ($urandom % 5);
        end
        2: if (reqv != 0 && arb_served < arb_want) begin
          rd_sel = reqv;
          arb_served++;
        end
        3: if (reqv != 0 && bus.CTS && arb_served < arb_want) begin
          rd_sel = reqv;
          arb_served++;
        end
        default: rd_sel = '0;
      endcase
    end
  end

  // Monitor: every effective pop must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rd_sel != 0 && !bus.empty) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: got flit %0h, required no pop", bus.Data_out);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", bus.Data_out, e.f);
          check("pop_req", 32'(reqv), 32'(e.dir));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    bus.RX = '0;
    bus.DRTS = 1'b0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    check("rst_cts", 32'(bus.CTS), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_req", 32'(reqv), 0);
    check("rst_err", 32'(bus.err), 0);

    // Latency: DRTS in t, CTS in t+1, non-empty in t+2, Req_E in t+3.
    f = mk(HDR, 2, 1);
    bus.RX = f;
    bus.DRTS = 1'b1;
    check("lat_cts_t", 32'(bus.CTS), 0);
    cycles(1);
    check("lat_cts_t1", 32'(bus.CTS), 1);
    check("lat_empty_t1", 32'(bus.empty), 1);
    model_push(f);
    bus.DRTS = 1'b0;
    cycles(1);
    check("lat_empty_t2", 32'(bus.empty), 0);
    check("lat_req_t2", 32'(reqv), 0);
    check("lat_data_t2", bus.Data_out, f);
    cycles(1);
    check("lat_req_t3", 32'(reqv), 32'(5'b01000));
    arb_mode = 1;
    send_flit(mk(BODY, 2, 1));
    send_flit(mk(BODY, 2, 1));
    send_flit(mk(TAIL, 2, 1));
    drain("pkt_e");

    // XY coverage around (1,1), including unsigned far coordinates.
    send_pkt(0, 1, 0);
    send_pkt(1, 2, 1);
    send_pkt(1, 0, 0);
    send_pkt(1, 1, 1);
    send_pkt(15, 0, 0);
    send_pkt(1, 15, 0);
    drain("xy");

    // Full FIFO back-pressure, then one pop reopens exactly one slot.
    arb_mode = 0;
    send_flit(mk(HDR, 0, 1));
    send_flit(mk(BODY, 0, 1));
    send_flit(mk(BODY, 0, 1));
    send_flit(mk(BODY, 0, 1));
    bus.RX = mk(TAIL, 0, 1);
    bus.DRTS = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check("full_cts_low", 32'(bus.CTS), 0);
    end
    bus.DRTS = 1'b0;
    arb_want++;
    arb_mode = 2;
    send_flit(mk(TAIL, 0, 1));
    bus.RX = mk(HDR, 2, 2);
    bus.DRTS = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check("refull_cts_low", 32'(bus.CTS), 0);
    end
    bus.DRTS = 1'b0;
    arb_mode = 1;
    drain("full");

    // Write and pop in the same cycle at count 2 keeps the count at 2.
    arb_mode = 0;
    send_flit(mk(HDR, 1, 2));
    send_flit(mk(BODY, 1, 2));
    cycles(2);
    arb_want++;
    arb_mode = 3;
    send_flit(mk(BODY, 1, 2));
    arb_mode = 0;
    send_flit(mk(BODY, 1, 2));
    send_flit(mk(TAIL, 1, 2));
    bus.RX = mk(HDR, 0, 0);
    bus.DRTS = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check("simul_cts_low", 32'(bus.CTS), 0);
    end
    bus.DRTS = 1'b0;
    arb_mode = 1;
    drain("simul");

    // Stray body at the head while idle.
    arb_mode = 0;
    check("pre_stray_err", 32'(bus.err), 0);
    send_flit(mk(BODY, 2, 2));
    cycles(3);
    check("stray_err", 32'(bus.err), 1);
    check("stray_empty", 32'(bus.empty), 1);
    check("stray_req", 32'(reqv), 0);

    // Randomised traffic with occasional strays between packets.
    arb_mode = 1;
    for (int p = 0; p < 25; p++) begin
      int dx, dy;
      if ($urandom % 6 == 0) send_flit(mk(($urandom % 2) ? BODY : TAIL, 1, 1));
      dx = ($urandom % 4 == 3) ? 15 : int'($urandom % 3);
      dy = ($urandom % 4 == 3) ? 15 : int'($urandom % 3);
      send_pkt(dx, dy, int'($urandom % 3));
    end
    drain("rand");
    check("rand_err_sticky", 32'(bus.err), 32'(err_exp));

    // Reset in the middle of a packet.
    arb_mode = 0;
    send_flit(mk(HDR, 0, 0));
    send_flit(mk(BODY, 0, 0));
    bus.RX = mk(BODY, 0, 0);
    bus.DRTS = 1'b1;
    cycles(2);
    check("mid_req", 32'(reqv), 32'(5'b00100));
    rst = 1'b1;
    cycles(1);
    check("mid_rst_err", 32'(bus.err), 0);
    check("mid_rst_empty", 32'(bus.empty), 1);
    check("mid_rst_req", 32'(reqv), 0);
    check("mid_rst_cts", 32'(bus.CTS), 0);
    bus.DRTS = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    in_pkt = 0;
    err_exp = 1'b0;
    cycles(1);

    arb_mode = 1;
    send_pkt(0, 2, 1);
    drain("post_rst");
    check("post_rst_err", 32'(bus.err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
